stopwatch_ctrl: RTL and testbench

- Controls a 4-digit BCD stopwatch: start/stop/clear FSM, tick prescaler, and cascade enables for four mod-10 digit counters.
- Also time-multiplexes the digits onto a common-anode seven-segment display.
- Sits between the button synchronisers/debouncers and the board display pins.

---
 rtl/stopwatch_ctrl_pkg.sv | 42 ++++
 rtl/stopwatch_ctrl_bcd_digit.sv | 30 +++
 rtl/stopwatch_ctrl.sv | 125 ++++++++++++
 tb/tb_stopwatch_ctrl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_ctrl_pkg.sv
// Shared definitions for the stopwatch controller: FSM encoding, BCD limit,
// and the common-anode seven-segment patterns with their decoder.
package stopwatch_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  localparam logic [3:0] BCD_MAX = 4'd9;

  // Segment order {g,f,e,d,c,b,a}; a 0 lights the segment.
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_bcd_digit.sv
// One mod-10 BCD digit with synchronous clear; carry marks an enabled 9->0
// roll so digits can be chained into a decade counter.
module bcd_digit
  import stopwatch_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  output logic [3:0] q,
  output logic       carry
);

  logic [3:0] r_q;

  // NOTE: clocked state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_q <= 4'd0;
    else if (clr)
      r_q <= 4'd0;
    else if (en)
      r_q <= (r_q == BCD_MAX) ? 4'd0 : r_q + 4'd1;
  end

  assign q     = r_q;
  assign carry = en && (r_q == BCD_MAX);

endmodule

// File: rtl/stopwatch_ctrl.sv
// 4-digit BCD stopwatch: run/pause/clear FSM, tick prescaler, digit cascade
// and a multiplexed common-anode seven-segment scanner.
module stopwatch_ctrl
  import stopwatch_ctrl_pkg::*;
#(
  parameter int TICK_DIV = 100000,
  parameter int SCAN_DIV = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_stop,
  input  logic        clear,
  output logic        running,
  output logic        overflow,
  output logic [15:0] digits,
  output logic [3:0]  an,
  output logic [6:0]  seg
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int SW = $clog2(SCAN_DIV);

  state_t          r_state, w_next_state;
  logic            w_clr;
  logic [TW-1:0]   r_presc;
  logic            w_tick;
  logic [4:0]      w_en;
  logic [15:0]     w_digits;
  logic            r_running, r_overflow;
  logic [SW-1:0]   r_scan;
  logic [1:0]      r_sel;
  logic [3:0]      r_an;
  logic [6:0]      r_seg;

  // NOTE: every output of this block gets a default first so no path through
  // the case leaves a signal unassigned, which would infer a latch.
  always_comb begin
    w_next_state = r_state;
    w_clr        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (clear)           w_clr = 1'b1;
        else if (start_stop) w_next_state = ST_RUN;
      end
      ST_RUN: begin
        if (start_stop) w_next_state = ST_PAUSE;
      end
      ST_PAUSE: begin
        if (clear) begin
          w_next_state = ST_IDLE;
          w_clr        = 1'b1;
        end else if (start_stop) begin
          w_next_state = ST_RUN;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_running <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_running <= (w_next_state == ST_RUN);
    end
  end

  // Prescaler is zero throughout IDLE, so a fresh start always begins at 0;
  // PAUSE leaves it untouched so a resume continues mid-period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_presc <= '0;
    else if (r_state == ST_RUN)
      r_presc <= w_tick ? '0 : r_presc + 1'b1;
    else if (r_state == ST_IDLE)
      r_presc <= '0;
  end

  assign w_tick  = (r_state == ST_RUN) && (r_presc == TW'(TICK_DIV - 1));
  assign w_en[0] = w_tick;

  for (genvar k = 0; k < 4; k++) begin : g_digit
    bcd_digit u_digit (
      .clk   (clk),
      .rst   (rst),
      .clr   (w_clr),
      .en    (w_en[k]),
      .q     (w_digits[4*k +: 4]),
      .carry (w_en[k+1])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          r_overflow <= 1'b0;
    else if (w_clr)   r_overflow <= 1'b0;
    else if (w_en[4]) r_overflow <= 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_scan <= '0;
      r_sel  <= 2'd0;
      r_an   <= 4'b1111;
      r_seg  <= SEG_BLANK;
    end else begin
      if (r_scan == SW'(SCAN_DIV - 1)) begin
        r_scan <= '0;
        r_sel  <= r_sel + 2'd1;
      end else begin
        r_scan <= r_scan + 1'b1;
      end
      r_an  <= ~(4'b0001 << r_sel);
      r_seg <= seg_decode(w_digits[{r_sel, 2'b00} +: 4]);
    end
  end

  assign running  = r_running;
  assign overflow = r_overflow;
  assign digits   = w_digits;
  assign an       = r_an;
  assign seg      = r_seg;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl: an arithmetic stopwatch model checked
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_stopwatch_ctrl;

  localparam int TICK_DIV = 4;
  localparam int SCAN_DIV = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_stop = 1'b0;
  logic        clear = 1'b0;
  logic        running, overflow;
  logic [15:0] digits;
  logic [3:0]  an;
  logic [6:0]  seg;

  stopwatch_ctrl #(.TICK_DIV(TICK_DIV), .SCAN_DIV(SCAN_DIV)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_stop (start_stop),
    .clear      (clear),
    .running    (running),
    .overflow   (overflow),
    .digits     (digits),
    .an         (an),
    .seg        (seg)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Model: count held as a plain integer 0..9999, display slot derived from
  // the number of edges since reset.
  logic [6:0] seg_tbl [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000};

  int         m_count, m_phase, m_n;
  bit         m_run, m_paused, m_ovf;
  logic [3:0] m_an;
  logic [6:0] m_seg;

  function automatic int digit_of(input int v, input int k);
    int t = v;
    for (int i = 0; i < k; i++) t = t / 10;
    return t % 10;
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] b;
    for (int k = 0; k < 4; k++) b[4*k +: 4] = 4'(digit_of(v, k));
    return b;
  endfunction

  always @(posedge clk or posedge rst) begin : model
    int c, ph, sel;
    bit r, p, o;
    if (rst) begin
      m_count <= 0; m_phase <= 0; m_n <= 0;
      m_run <= 1'b0; m_paused <= 1'b0; m_ovf <= 1'b0;
      m_an <= 4'b1111; m_seg <= 7'b1111111;
    end else begin
      c = m_count; ph = m_phase; r = m_run; p = m_paused; o = m_ovf;
      sel = (m_n / SCAN_DIV) % 4;
      m_an  <= ~(4'b0001 << sel);
      m_seg <= seg_tbl[digit_of(m_count, sel)];
      m_n   <= m_n + 1;
      if (m_run) begin
        if (ph == TICK_DIV - 1) begin
          ph = 0;
          c  = c + 1;
          if (c == 10000) begin c = 0; o = 1'b1; end
        end else begin
          ph = ph + 1;
        end
      end
      if (m_run) begin
        if (start_stop) begin r = 1'b0; p = 1'b1; end
      end else if (clear) begin
        c = 0; o = 1'b0; ph = 0; r = 1'b0; p = 1'b0;
      end else if (start_stop) begin
        r = 1'b1;
        if (!p) ph = 0;
        p = 1'b0;
      end
      m_count <= c; m_phase <= ph; m_run <= r; m_paused <= p; m_ovf <= o;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model digits",   {16'd0, digits}, {16'd0, to_bcd(m_count)});
      check("model running",  {31'd0, running}, {31'd0, m_run});
      check("model overflow", {31'd0, overflow}, {31'd0, m_ovf});
      check("model an",       {28'd0, an}, {28'd0, m_an});
      check("model seg",      {25'd0, seg}, {25'd0, m_seg});
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic pulse(input logic s, input logic c);
    start_stop = s;
    clear      = c;
    step(1);
    start_stop = 1'b0;
    clear      = 1'b0;
  endtask

  initial begin
    logic [3:0] exp_an [8];
    logic [3:0] prev_an;
    bit         found;

    exp_an = '{4'b1110, 4'b1110, 4'b1101, 4'b1101,
               4'b1011, 4'b1011, 4'b0111, 4'b0111};

    step(2);
    check("reset an",       {28'd0, an}, 32'hF);
    check("reset seg",      {25'd0, seg}, 32'h7F);
    check("reset digits",   {16'd0, digits}, 32'h0);
    check("reset running",  {31'd0, running}, 32'h0);
    check("reset overflow", {31'd0, overflow}, 32'h0);
    rst    = 1'b0;
    chk_en = 1'b1;
    step(1);
    check("first scan an",  {28'd0, an}, 32'hE);
    check("first scan seg", {25'd0, seg}, 32'h40);

    // Start, first two increments, decade carries.
    pulse(1'b1, 1'b0);
    check("start running", {31'd0, running}, 32'h1);
    step(4);       check("digits 1", {16'd0, digits}, 32'h0001);
    step(4);       check("digits 2", {16'd0, digits}, 32'h0002);
    step(28);      check("digits 9", {16'd0, digits}, 32'h0009);
    step(4);       check("carry 10", {16'd0, digits}, 32'h0010);
    step(4 * 989); check("digits 999", {16'd0, digits}, 32'h0999);
    step(4);       check("carry 1000", {16'd0, digits}, 32'h1000);
    step(4 * 8999); check("digits 9999", {16'd0, digits}, 32'h9999);
    check("no overflow yet", {31'd0, overflow}, 32'h0);
    step(4);
    check("wrap digits",   {16'd0, digits}, 32'h0000);
    check("wrap overflow", {31'd0, overflow}, 32'h1);
    check("wrap running",  {31'd0, running}, 32'h1);

    pulse(1'b0, 1'b1);
    check("clear in run running",  {31'd0, running}, 32'h1);
    check("clear in run overflow", {31'd0, overflow}, 32'h1);
    pulse(1'b1, 1'b0);
    check("paused", {31'd0, running}, 32'h0);
    pulse(1'b0, 1'b1);
    check("clear digits",   {16'd0, digits}, 32'h0);
    check("clear overflow", {31'd0, overflow}, 32'h0);
    check("clear running",  {31'd0, running}, 32'h0);

    // Pause with prescaler at 2, resume, increment lands two edges later.
    pulse(1'b1, 1'b0);
    step(1);
    pulse(1'b1, 1'b0);
    check("mid pause running", {31'd0, running}, 32'h0);
    step(50);
    check("frozen digits", {16'd0, digits}, 32'h0);
    pulse(1'b1, 1'b0);
    check("resume running", {31'd0, running}, 32'h1);
    check("resume +0", {16'd0, digits}, 32'h0);
    step(1);  check("resume +1", {16'd0, digits}, 32'h0);
    step(1);  check("resume +2", {16'd0, digits}, 32'h0001);

    pulse(1'b1, 1'b1);
    check("both in run running", {31'd0, running}, 32'h0);
    check("both in run digits",  {16'd0, digits}, 32'h0001);
    pulse(1'b1, 1'b1);
    check("both in pause running", {31'd0, running}, 32'h0);
    check("both in pause digits",  {16'd0, digits}, 32'h0);

    // Count to 1234, pause, and watch the scan.
    pulse(1'b1, 1'b0);
    step(4 * 1234);
    pulse(1'b1, 1'b0);
    check("digits 1234", {16'd0, digits}, 32'h1234);
    check("1234 paused", {31'd0, running}, 32'h0);

    found   = 1'b0;
    prev_an = 4'b1111;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (prev_an == 4'b0111 && an == 4'b1110) found = 1'b1;
      else prev_an = an;
    end
    check("scan sync found", {31'd0, found}, 32'h1);
    if (found) begin
      for (int j = 0; j < 8; j++) begin
        if (j > 0) @(negedge clk);
        check("scan an order", {28'd0, an}, {28'd0, exp_an[j]});
        if (j == 0) check("seg d0=4", {25'd0, seg}, 32'h19);
        if (j == 6) check("seg d3=1", {25'd0, seg}, 32'h79);
      end
    end

    // Asynchronous reset in the middle of a slot.
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("async an",      {28'd0, an}, 32'hF);
    check("async seg",     {25'd0, seg}, 32'h7F);
    check("async digits",  {16'd0, digits}, 32'h0);
    check("async running", {31'd0, running}, 32'h0);
    step(2);
    check("held blank", {28'd0, an}, 32'hF);
    rst = 1'b0;
    step(1);
    check("post reset an",  {28'd0, an}, 32'hE);
    check("post reset seg", {25'd0, seg}, 32'h40);

    step(3);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
